// File: rtl/crypt_serial_tx_if.sv
// Word handshake and serial-line signals of the parity-framed transmitter.
// master: the word source; slave: crypt_serial_tx.
interface crypt_serial_tx_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] Data_Tx;
  logic              Tx_Valid;
  logic              Tx_Ready;
  logic              Tx;
  logic              CLK_B;
  logic              Tx_Busy;
  logic              Tx_Done;

  modport master (
    output Data_Tx, Tx_Valid,
    input  Tx_Ready, Tx, CLK_B, Tx_Busy, Tx_Done
  );

  modport slave (
    input  Data_Tx, Tx_Valid,
    output Tx_Ready, Tx, CLK_B, Tx_Busy, Tx_Done
  );
endinterface

// File: rtl/crypt_serial_tx.sv
// Parity-framed serial transmitter: start, 32 data bits LSB first, optional even
// parity (macro CRYPT_TX_PARITY_EN), stop. All outputs come straight from flops.
module crypt_serial_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_W       = 32
) (
  input  logic              CLK,
  input  logic              CLR,
  crypt_serial_tx_if.slave  bus
);
  localparam int              CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);
  localparam logic [4:0]       IDX_LAST = 5'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef CRYPT_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  baud_cnt;
  logic [4:0]        bit_idx;
  logic [DATA_W-1:0] shift;
  logic              tx_r;
  logic              ready_r;
  logic              busy_r;
  logic              done_r;
  logic              clkb_r;
`ifdef CRYPT_TX_PARITY_EN
  logic              parity_r;
`endif

  logic bit_end;
  assign bit_end = (baud_cnt == CNT_LAST);

  // NOTE: every register here is assigned with <= so all of them see the
  // pre-edge values of one another; a blocking '=' would create ordering races.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx_r     <= 1'b1;
      ready_r  <= 1'b1;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      clkb_r   <= 1'b0;
`ifdef CRYPT_TX_PARITY_EN
      parity_r <= 1'b0;
`endif
    end else begin
      done_r <= 1'b0;
      clkb_r <= 1'b0;
      if (state == IDLE) begin
        if (bus.Tx_Valid) begin
          shift    <= bus.Data_Tx;
`ifdef CRYPT_TX_PARITY_EN
          parity_r <= ^bus.Data_Tx;
`endif
          bit_idx  <= '0;
          baud_cnt <= '0;
          tx_r     <= 1'b0;
          ready_r  <= 1'b0;
          busy_r   <= 1'b1;
          state    <= START;
        end
      end else begin
        baud_cnt <= bit_end ? '0 : baud_cnt + CNT_W'(1);
        // Pulses are raised one cycle early so they land on the last cycle of the bit.
        clkb_r   <= (baud_cnt == CNT_PRE);
        done_r   <= (state == STOP) && (baud_cnt == CNT_PRE);
        if (bit_end) begin
          unique case (state)
            START: begin
              tx_r  <= shift[0];
              state <= DATA;
            end
            DATA: begin
              shift   <= shift >> 1;
              bit_idx <= bit_idx + 5'd1;
              if (bit_idx == IDX_LAST) begin
`ifdef CRYPT_TX_PARITY_EN
                tx_r  <= parity_r;
                state <= PARITY;
`else
                tx_r  <= 1'b1;
                state <= STOP;
`endif
              end else begin
                tx_r <= shift[1];
              end
            end
`ifdef CRYPT_TX_PARITY_EN
            PARITY: begin
              tx_r  <= 1'b1;
              state <= STOP;
            end
`endif
            STOP: begin
              tx_r    <= 1'b1;
              ready_r <= 1'b1;
              busy_r  <= 1'b0;
              state   <= IDLE;
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

  assign bus.Tx       = tx_r;
  assign bus.Tx_Ready = ready_r;
  assign bus.Tx_Busy  = busy_r;
  assign bus.Tx_Done  = done_r;
  assign bus.CLK_B    = clkb_r;

endmodule

// File: tb/tb_crypt_serial_tx.sv
// Directed bench for crypt_serial_tx at CLKS_PER_BIT=4: table of words plus
// hand-written reset, back-to-back and reset-with-valid sequences.
module tb_crypt_serial_tx;
  localparam int N = 4;
`ifdef CRYPT_TX_PARITY_EN
  localparam int FB     = 35;
  localparam bit PAR_EN = 1'b1;
`else
  localparam int FB     = 34;
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int FL = FB * N;

  logic CLK = 1'b0;
  logic CLR = 1'b1;

  crypt_serial_tx_if #(.DATA_W(32)) bus ();

  crypt_serial_tx #(.CLKS_PER_BIT(N), .DATA_W(32)) dut (
    .CLK (CLK),
    .CLR (CLR),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  logic cap_tx    [1:FL];
  logic cap_done  [1:FL];
  logic cap_clkb  [1:FL];
  logic cap_busy  [1:FL];
  logic cap_ready [1:FL];

  typedef struct {
    logic [31:0] word;
    logic        exp_par;
    int          chg_at;
    logic [31:0] chg_val;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance to the next cycle and settle past the edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic accept(input logic [31:0] w, input bit hold);
    bus.Data_Tx  = w;
    bus.Tx_Valid = 1'b1;
    tick();
    if (!hold) bus.Tx_Valid = 1'b0;
  endtask

  // Record cycles A+1..A+FL; optionally change Data_Tx at cycle A+chg_at.
  task automatic capture(input int chg_at, input logic [31:0] chg_val);
    for (int c = 1; c <= FL; c++) begin
      cap_tx[c]    = bus.Tx;
      cap_done[c]  = bus.Tx_Done;
      cap_clkb[c]  = bus.CLK_B;
      cap_busy[c]  = bus.Tx_Busy;
      cap_ready[c] = bus.Tx_Ready;
      if (c == chg_at) bus.Data_Tx = chg_val;
      if (c < FL) tick();
    end
  endtask

  task automatic check_frame(input string name, input logic [31:0] w, input logic exp_par);
    int          bad_cycles;
    int          n_done;
    int          n_clkb;
    int          n_busy;
    int          n_ready;
    logic [31:0] rx_word;
    logic        exp_bit;
    int          k;
    bad_cycles = 0; n_done = 0; n_clkb = 0; n_busy = 0; n_ready = 0;
    for (int c = 1; c <= FL; c++) begin
      k = (c - 1) / N;
      if (k == 0)                     exp_bit = 1'b0;
      else if (k <= 32)               exp_bit = w[k-1];
      else if (PAR_EN && k == 33)     exp_bit = exp_par;
      else                            exp_bit = 1'b1;
      if (cap_tx[c] !== exp_bit) bad_cycles++;
      if (cap_done[c] === 1'b1)  n_done++;
      if (cap_clkb[c] === 1'b1)  n_clkb++;
      if (cap_busy[c] === 1'b1)  n_busy++;
      if (cap_ready[c] !== 1'b0) n_ready++;
    end
    for (int b = 0; b < 32; b++) rx_word[b] = cap_tx[1 + (b + 1) * N + N / 2];
    check({name, " tx waveform bad cycles"}, bad_cycles, 0);
    check({name, " start bit"}, {31'd0, cap_tx[1 + N / 2]}, 0);
    check({name, " recovered word"}, rx_word, w);
    if (PAR_EN) check({name, " parity bit"}, {31'd0, cap_tx[1 + 33 * N + N / 2]}, {31'd0, exp_par});
    check({name, " stop bit"}, {31'd0, cap_tx[1 + (FB - 1) * N + N / 2]}, 1);
    check({name, " Tx_Done at last cycle"}, {31'd0, cap_done[FL]}, 1);
    check({name, " Tx_Done pulse count"}, n_done, 1);
    check({name, " first CLK_B"}, {31'd0, cap_clkb[N]}, 1);
    check({name, " CLK_B pulse count"}, n_clkb, FB);
    check({name, " Tx_Busy cycles"}, n_busy, FL);
    check({name, " Tx_Ready high cycles"}, n_ready, 0);
  endtask

  task automatic check_idle(input string name);
    check({name, " Tx"},       {31'd0, bus.Tx},       1);
    check({name, " Tx_Ready"}, {31'd0, bus.Tx_Ready}, 1);
    check({name, " Tx_Busy"},  {31'd0, bus.Tx_Busy},  0);
    check({name, " Tx_Done"},  {31'd0, bus.Tx_Done},  0);
    check({name, " CLK_B"},    {31'd0, bus.CLK_B},    0);
  endtask

  initial begin
    int n_done;
    int n_low;

    // Parity values are hand-counted from the set-bit totals of each word.
    vecs[0] = '{word: 32'h0000_0001, exp_par: 1'b1, chg_at: 0,  chg_val: 32'h0};
    vecs[1] = '{word: 32'hA5A5_A5A5, exp_par: 1'b0, chg_at: 0,  chg_val: 32'h0};
    vecs[2] = '{word: 32'h8000_0000, exp_par: 1'b1, chg_at: 0,  chg_val: 32'h0};
    vecs[3] = '{word: 32'h0F0F_1234, exp_par: 1'b1, chg_at: 50, chg_val: 32'hFFFF_FFFF};
    vecs[4] = '{word: 32'hFFFF_FFFF, exp_par: 1'b0, chg_at: 70, chg_val: 32'h0000_0000};

    bus.Data_Tx  = 32'h0;
    bus.Tx_Valid = 1'b0;
    CLR          = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_idle($sformatf("reset cycle %0d", i));
    end
    CLR = 1'b0;
    tick();
    check_idle("idle after reset");

    for (int v = 0; v < 5; v++) begin
      accept(vecs[v].word, 1'b0);
      capture(vecs[v].chg_at, vecs[v].chg_val);
      check_frame($sformatf("vec%0d", v), vecs[v].word, vecs[v].exp_par);
      tick();
      check_idle($sformatf("vec%0d post-frame", v));
    end

    // Back-to-back with Tx_Valid held: one idle-high cycle between frames.
    accept(32'h1234_5678, 1'b1);
    bus.Data_Tx = 32'hDEAD_BEEF;
    capture(0, 32'h0);
    check_frame("b2b first", 32'h1234_5678, 1'b1);
    tick();
    check("b2b gap Tx", {31'd0, bus.Tx}, 1);
    check("b2b gap Tx_Ready", {31'd0, bus.Tx_Ready}, 1);
    tick();
    bus.Tx_Valid = 1'b0;
    capture(0, 32'h0);
    check_frame("b2b second", 32'hDEAD_BEEF, 1'b0);
    tick();
    check_idle("b2b post-frame");

    // Reset mid-frame at cycle A+60.
    accept(32'hCAFE_0001, 1'b0);
    for (int c = 1; c < 60; c++) tick();
    CLR = 1'b1;
    tick();
    CLR = 1'b0;
    check_idle("mid-frame reset");
    n_done = 0;
    n_low  = 0;
    for (int c = 0; c < FL; c++) begin
      tick();
      if (bus.Tx_Done === 1'b1) n_done++;
      if (bus.Tx !== 1'b1)      n_low++;
    end
    check("after reset Tx_Done count", n_done, 0);
    check("after reset Tx low cycles", n_low, 0);
    accept(32'h1357_9BDF, 1'b0);
    capture(0, 32'h0);
    check_frame("after reset frame", 32'h1357_9BDF, 1'b0);
    tick();
    check_idle("after reset post-frame");

    // Reset and Tx_Valid together: no accept.
    CLR          = 1'b1;
    bus.Data_Tx  = 32'h0000_0000;
    bus.Tx_Valid = 1'b1;
    tick();
    CLR          = 1'b0;
    bus.Tx_Valid = 1'b0;
    check_idle("clr+valid");
    tick();
    check_idle("clr+valid next");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
